aes_shift_rows_serializer: RTL

Column-serial ShiftRows stage that sits directly upstream of the MixColumns column mixer (aes_mixw).
- Accepts a full 128-bit post-SubBytes state through a valid/ready handshake.
- Applies ShiftRows and stores the result.
- Emits the state one 32-bit column per handshake, so a single column mixer serves all four columns.
- Flags the final AES round so downstream logic bypasses MixColumns.

---
 rtl/aes_shift_rows_serializer_pkg.sv | 28 ++
 rtl/aes_shift_rows_serializer_shift_rows.sv | 20 ++
 rtl/aes_shift_rows_serializer.sv | 88 ++++++++
 3 files changed

// File: rtl/aes_shift_rows_serializer_pkg.sv
// Shared AES datapath definitions for the column-serial ShiftRows stage.
// Also holds the serializer FSM encoding and a column-select helper.
package aes_shift_rows_serializer_pkg;

  localparam int unsigned AES_NB      = 4;
  localparam int unsigned AES_BYTE_W  = 8;
  localparam int unsigned AES_COL_W   = 32;
  localparam int unsigned AES_STATE_W = 128;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } sr_state_e;

  // Column c of a column-major state; column 0 occupies the MSBs.
  function automatic logic [AES_COL_W-1:0] state_col(input logic [AES_STATE_W-1:0] s,
                                                     input logic [1:0]             c);
    logic [AES_COL_W-1:0] col;
    case (c)
      2'd0:    col = s[127:96];
      2'd1:    col = s[95:64];
      2'd2:    col = s[63:32];
      default: col = s[31:0];
    endcase
    return col;
  endfunction

endpackage

// File: rtl/aes_shift_rows_serializer_shift_rows.sv
// Combinational AES ShiftRows on a column-major 128-bit state.
// Output column c, byte r takes input column (c+r) mod 4, byte r.
module aes_shift_rows
  import aes_shift_rows_serializer_pkg::*;
(
  input  logic [AES_STATE_W-1:0] data_i,
  output logic [AES_STATE_W-1:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int unsigned c = 0; c < AES_NB; c++) begin
      for (int unsigned r = 0; r < AES_NB; r++) begin
        data_o[AES_STATE_W-1-AES_COL_W*c-AES_BYTE_W*r -: AES_BYTE_W] =
          data_i[AES_STATE_W-1-AES_COL_W*((c+r)%AES_NB)-AES_BYTE_W*r -: AES_BYTE_W];
      end
    end
  end

endmodule

// File: rtl/aes_shift_rows_serializer.sv
// Column-serial ShiftRows stage feeding the MixColumns column mixer.
// Buffers one shifted state and emits it one 32-bit column per handshake.
module aes_shift_rows_serializer
  import aes_shift_rows_serializer_pkg::*;
(
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   data_v_i,
  input  logic [AES_STATE_W-1:0] data_i,
  input  logic                   last_i,
  output logic                   data_rdy_o,
  output logic                   col_v_o,
  output logic [AES_COL_W-1:0]   col_o,
  output logic [1:0]             col_idx_o,
  output logic                   col_last_o,
  output logic                   round_last_o,
  input  logic                   col_rdy_i
);

  sr_state_e              state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [AES_STATE_W-1:0] buf_q;
  logic [AES_STATE_W-1:0] shifted;
  logic                   rl_q;
  logic                   accept;

  aes_shift_rows u_shift_rows (
    .data_i (data_i),
    .data_o (shifted)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_rdy_o = 1'b0;
    col_v_o    = 1'b0;
    accept     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        data_rdy_o = 1'b1;
        if (data_v_i) begin
          state_d = ST_SEND;
          idx_d   = 2'd0;
        end
      end
      ST_SEND: begin
        col_v_o    = 1'b1;
        // Ready opens during the final column transfer so blocks stream without a bubble.
        data_rdy_o = (idx_q == 2'd3) & col_rdy_i;
        if (col_rdy_i) begin
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
          end else begin
            idx_d   = 2'd0;
            state_d = data_v_i ? ST_SEND : ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
      end
    endcase
    accept = data_v_i & data_rdy_o;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      buf_q   <= '0;
      rl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        buf_q <= shifted;
        rl_q  <= last_i;
      end
    end
  end

  assign col_o        = state_col(buf_q, idx_q);
  assign col_idx_o    = idx_q;
  assign col_last_o   = (idx_q == 2'd3);
  assign round_last_o = rl_q;

endmodule
